xor_pipe: RTL and testbench

Parametrised, pipelined successor to the single-bit registered XOR gate. Combines NUM_IN operand channels of WIDTH bits per beat, in one of four modes (XOR, XNOR, running XOR accumulate, parity), behind valid/ready handshakes on both sides. A 2-entry skid buffer gives full throughput with a registered in_ready, so the block drops directly into the AXI cache/FIFO datapaths as a checksum or scramble stage.

---
 rtl/xor_pipe_pkg.sv | 38 +++
 rtl/xor_skid_buf.sv | 79 +++++++
 rtl/xor_pipe.sv | 75 +++++++
 tb/tb_xor_pipe.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/xor_pipe_pkg.sv
// xor_pipe_pkg: shared definitions for the xor_pipe checksum/scramble stage.
//   mode_e              - operation selector carried with each beat
//   xor_reduce_channels - bitwise XOR of num_in channels of width bits each,
//                         packed as channel k at [k*width +: width]
package xor_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_XOR    = 2'd0,
    MODE_XNOR   = 2'd1,
    MODE_ACC    = 2'd2,
    MODE_PARITY = 2'd3
  } mode_e;

  // Upper bounds for the reduce helper; callers zero-extend into these.
  localparam int unsigned XP_MAX_WIDTH = 64;
  localparam int unsigned XP_MAX_IN    = 32;
  localparam int unsigned XP_MAX_DATA  = XP_MAX_WIDTH * XP_MAX_IN;

  function automatic logic [XP_MAX_WIDTH-1:0] xor_reduce_channels(
    input logic [XP_MAX_DATA-1:0] data,
    input int unsigned            num_in,
    input int unsigned            width
  );
    logic [XP_MAX_WIDTH-1:0] r;
    logic [XP_MAX_WIDTH-1:0] mask;
    r    = '0;
    // Shifting an all-ones word by width leaves 0 when width == XP_MAX_WIDTH,
    // so the inverted mask is all ones in that case as well.
    mask = ~({XP_MAX_WIDTH{1'b1}} << width);
    for (int unsigned k = 0; k < XP_MAX_IN; k++) begin
      if (k < num_in) begin
        r = r ^ (XP_MAX_WIDTH'(data >> (k * width)) & mask);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/xor_skid_buf.sv
// xor_skid_buf: generic WIDTH-bit 2-entry register slice.
//   clk, rst (sync, active low)
//   in_valid/in_ready/in_data    - upstream handshake; in_ready is registered
//   out_valid/out_ready/out_data - downstream handshake, driven from main
// main holds the presented result; skid absorbs one beat accepted while main
// is stalled. in_ready(next) = !skid_full(next).
module xor_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid, main_valid_n;
  logic [WIDTH-1:0] main_data,  main_data_n;
  logic             skid_valid, skid_valid_n;
  logic [WIDTH-1:0] skid_data,  skid_data_n;
  logic             ready_r,    ready_n;
  logic             accept, consume;

  assign accept  = in_valid && ready_r;
  assign consume = main_valid && out_ready;

  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;

    if (consume) begin
      if (skid_valid) begin
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
      end else begin
        main_valid_n = 1'b0;
      end
    end

    // accept cannot coincide with a full skid since ready_r is low then.
    if (accept) begin
      if (!main_valid || consume) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
      end else begin
        skid_valid_n = 1'b1;
        skid_data_n  = in_data;
      end
    end

    ready_n = !skid_valid_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_r    <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      ready_r    <= ready_n;
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/xor_pipe.sv
// xor_pipe: pipelined NUM_IN-channel XOR stage with valid/ready on both sides.
//   clk, rst (sync, active low)
//   mode     - 0 XOR, 1 XNOR, 2 ACC (running XOR), 3 PARITY; sampled per beat
//   acc_clr  - clears the accumulator on any cycle
//   in_valid/in_ready/in_data    - channel k at in_data[k*WIDTH +: WIDTH]
//   out_valid/out_ready/out_data - WIDTH-bit result, in acceptance order
module xor_pipe
  import xor_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    acc_clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data
);

  mode_e                  m;
  logic [XP_MAX_DATA-1:0] data_ext;
  logic [WIDTH-1:0]       x;
  logic [WIDTH-1:0]       acc;
  logic [WIDTH-1:0]       acc_next;
  logic [WIDTH-1:0]       result;
  logic                   accept;

  assign m        = mode_e'(mode);
  assign data_ext = XP_MAX_DATA'(in_data);
  assign x        = WIDTH'(xor_reduce_channels(data_ext, NUM_IN, WIDTH));
  assign accept   = in_valid && in_ready;

  // Clear is applied before folding in this beat's x.
  assign acc_next = (acc_clr ? '0 : acc) ^ x;

  always_comb begin
    result = x;
    case (m)
      MODE_XOR:    result = x;
      MODE_XNOR:   result = ~x;
      MODE_ACC:    result = acc_next;
      MODE_PARITY: result = {{(WIDTH-1){1'b0}}, ^x};
      default:     result = x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else if (accept && m == MODE_ACC) begin
      acc <= acc_next;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

  xor_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_xor_pipe.sv
// tb_xor_pipe: scoreboard bench for xor_pipe (WIDTH=8, NUM_IN=2).
// The driver pushes a hand-computed expected result on each accepted beat;
// the monitor pops and compares on every consumed result.
module tb_xor_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        acc_clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  expq[$];

  always #5 clk = ~clk;

  xor_pipe #(
    .WIDTH (8),
    .NUM_IN(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .acc_clr  (acc_clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Inputs change only 1 time unit after the rising edge, so at the falling
  // edge they equal what the next rising edge will sample.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL monitor: unexpected result %0h, scoreboard empty", out_data);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        if (out_data !== e) begin
          n_err++;
          $display("FAIL monitor: got %0h, expected %0h", out_data, e);
        end
      end
    end
  end

  // Offer one beat, hold until accepted (bounded), push its expected result.
  task automatic send(input logic [7:0] c0, input logic [7:0] c1, input logic [1:0] md,
                      input logic clr, input logic [7:0] exp);
    bit done;
    done     = 1'b0;
    in_data  = {c1, c0};
    mode     = md;
    acc_clr  = clr;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        expq.push_back(exp);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    rst       = 1'b0;
    mode      = 2'd0;
    acc_clr   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    out_ready = 1'b1;

    // 1. reset with in_valid high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1);

    // 2. XOR then XNOR, back to back, one-cycle latency
    send(8'hF0, 8'h3C, 2'd0, 1'b0, 8'hCC);
    chk("lat_xor_valid", out_valid, 1);
    chk("lat_xor_data", out_data, 8'hCC);
    send(8'hAA, 8'h55, 2'd1, 1'b0, 8'h00);
    chk("lat_xnor_valid", out_valid, 1);
    chk("lat_xnor_data", out_data, 8'h00);
    drain();

    // 3. backpressure: two beats fill main and skid, third waits
    out_ready = 1'b0;
    send(8'h01, 8'h00, 2'd0, 1'b0, 8'h01);
    chk("bp_in_ready_one", in_ready, 1);
    send(8'h02, 8'h00, 2'd0, 1'b0, 8'h02);
    chk("bp_in_ready_drop", in_ready, 0);
    in_data  = 16'h0003;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'h01);
      chk("bp_hold_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h03, 8'h00, 2'd0, 1'b0, 8'h03);
    drain();

    // 4. accumulate
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    send(8'h11, 8'h00, 2'd2, 1'b0, 8'h11);
    send(8'h00, 8'h22, 2'd2, 1'b0, 8'h33);
    send(8'h40, 8'h04, 2'd2, 1'b0, 8'h77);
    send(8'h08, 8'h00, 2'd2, 1'b1, 8'h08);

    // 5. parity leaves acc alone
    send(8'h07, 8'h00, 2'd3, 1'b0, 8'h01);
    send(8'h03, 8'h00, 2'd3, 1'b0, 8'h00);
    send(8'h00, 8'h00, 2'd2, 1'b0, 8'h08);
    drain();

    // 6. reset with both buffers full
    out_ready = 1'b0;
    send(8'hA5, 8'h00, 2'd0, 1'b0, 8'hA5);
    send(8'h5A, 8'h00, 2'd0, 1'b0, 8'h5A);
    chk("pre_rst_full", in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    expq.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(8'h01, 8'h00, 2'd2, 1'b0, 8'h01);
    chk("post_rst_data", out_data, 8'h01);
    @(posedge clk); #1;
    chk("post_rst_alone", out_valid, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
